// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, types and helpers for the instruction fetch
// front end (fetch_unit, fetch_fifo, fetch_fifo_chk).
//   XLEN           - datapath / address width
//   INSN_BYTES     - bytes per instruction word (sequential PC step)
//   MEM_RD_LATENCY - fixed instruction memory read latency in cycles; sizes
//                    the request tracker
//   fetch_entry_t  - one buffered instruction: {pc, inst}
package fetch_pkg;

    localparam int XLEN           = 32;
    localparam int INSN_BYTES     = 4;
    localparam int MEM_RD_LATENCY = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary (low two bits cleared).
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer of fetch_entry_t entries.
//   clk, rst_n - clock, synchronous active-low reset
//   push/wdata - write an entry (accepted when not full, or when a pop
//                frees a slot in the same cycle)
//   pop/rdata  - rdata is the head entry; pop removes it (ignored when empty)
//   flush      - synchronous clear, takes priority over push and pop
//   count, empty, full - occupancy status
// Also holds fetch_fifo_chk, the overflow checker instantiated by fetch_unit.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  fetch_entry_t                wdata,
    output fetch_entry_t                rdata,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        empty,
    output logic                        full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    fetch_entry_t  mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy; a pop frees a slot for a same-cycle push.
    always_comb begin
        do_pop_s  = pop & (count_r != {(AW+1){1'b0}});
        do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy update with reset/flush priority.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Status and head-entry outputs.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        count = count_r;
        empty = (count_r == {(AW+1){1'b0}});
        full  = (count_r == DEPTH_C);
    end

endmodule

// fetch_fifo_chk: a push into a full buffer with no simultaneous pop would
// lose an instruction; the fetch credit rule must make that impossible.
module fetch_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || flush)
                                    !(push && full && !pop))
        else $error("fetch_fifo overflow");

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end feeding decode from a BRAM with a
// fixed MEM_RD_LATENCY-cycle read latency.
//   clk, rst_n          - clock, synchronous active-low reset
//   fetch_en            - permit new memory requests
//   redirect_valid/pc   - flush and restart fetch at redirect_pc (word aligned)
//   mem_read_en/addr    - read request to instruction memory (addr 0 when idle)
//   mem_q               - read data, MEM_RD_LATENCY cycles after the request
//   inst_valid/ready    - handshake to decode
//   inst, inst_pc       - head instruction and its PC (0 when not valid)
// Optional macro FETCH_PERF_EN adds perf_issue_cnt, perf_drop_cnt and
// perf_stall_cnt wrapping event counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_q,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int LAT = MEM_RD_LATENCY;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    logic [XLEN-1:0]           pc_r;
    logic [LAT-1:0]            trk_valid_r;
    logic [LAT-1:0][XLEN-1:0]  trk_pc_r;
    logic [CW-1:0]             inflight_s;
    logic [CW:0]               occupancy_s;
    logic                      issue_s;
    logic                      push_s;
    logic                      pop_s;
    fetch_entry_t              wdata_s;
    fetch_entry_t              head_s;
    logic [CW-1:0]             fifo_count_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;

    // Credit check: requests in flight plus buffered entries must leave room,
    // so every returning word is guaranteed a slot (same-cycle pop not credited).
    always_comb begin
        inflight_s = {CW{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + {{(CW-1){1'b0}}, trk_valid_r[i]};
        end
        occupancy_s = {1'b0, inflight_s} + {1'b0, fifo_count_s};
        issue_s     = fetch_en & ~redirect_valid & (occupancy_s < DEPTH_C);
        mem_read_en = issue_s;
        mem_addr    = issue_s ? pc_r : 32'h0000_0000;
    end

    // Fetch PC: redirect has priority, otherwise advance on each issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= align_pc(redirect_pc);
        end else if (issue_s) begin
            pc_r <= pc_r + 32'(INSN_BYTES);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Latency tracker; the oldest stage marks the cycle mem_q holds its data.
    // A redirect invalidates every stage so stale returns are never buffered.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            trk_valid_r <= {LAT{1'b0}};
        end else begin
            trk_valid_r <= {trk_valid_r[LAT-2:0], issue_s};
        end
        trk_pc_r <= {trk_pc_r[LAT-2:0], pc_r};
    end

    // Buffer write/read control; a redirect drops both push and pop.
    always_comb begin
        push_s       = trk_valid_r[LAT-1] & ~redirect_valid;
        pop_s        = ~fifo_empty_s & inst_ready & ~redirect_valid;
        wdata_s.pc   = trk_pc_r[LAT-1];
        wdata_s.inst = mem_q;
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    fetch_fifo_chk u_fifo_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .full  (fifo_full_s)
    );

    // Decode-facing outputs, zeroed while the buffer is empty.
    always_comb begin
        inst_valid = ~fifo_empty_s;
        if (fifo_empty_s) begin
            inst    = 32'h0000_0000;
            inst_pc = 32'h0000_0000;
        end else begin
            inst    = head_s.inst;
            inst_pc = head_s.pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters; drops count the in-flight words a redirect discards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_cnt <= 32'h0000_0000;
            perf_drop_cnt  <= 32'h0000_0000;
            perf_stall_cnt <= 32'h0000_0000;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + {31'h0, issue_s};
            perf_drop_cnt  <= perf_drop_cnt + (redirect_valid ? 32'(inflight_s) : 32'h0000_0000);
            perf_stall_cnt <= perf_stall_cnt + {31'h0, inst_valid & ~inst_ready};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phases plus randomized traffic for fetch_unit,
// checked every cycle against a queue-based transaction model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_q;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_drop_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_q          (mem_q),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents: word i holds A000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Memory with a two-cycle read pipeline; junk on idle cycles.
    logic        m1_v = 1'b0, m2_v = 1'b0;
    logic [31:0] m1_a = 32'h0, m2_a = 32'h0, junk = 32'h0;
    always @(posedge clk) begin
        m1_v <= mem_read_en;
        m1_a <= mem_addr;
        m2_v <= m1_v;
        m2_a <= m1_a;
        junk <= $urandom;
    end
    assign mem_q = m2_v ? mem_word(m2_a) : junk;

    // Reference model: outstanding requests with the cycle their data returns,
    // and the buffered instruction PCs in delivery order.
    typedef struct {
        logic [31:0] pc;
        int          due;
    } req_t;

    req_t        m_inf[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_pc;
    logic        m_known = 1'b0;
    int          cyc = 0;
    logic [31:0] m_issue_cnt, m_drop_cnt, m_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance model.
    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic rn);
        logic        exp_issue;
        logic        exp_valid;
        logic [31:0] head_pc;
        @(negedge clk);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        rst_n          = rn;
        #1;
        exp_issue = fe && !rv && ((m_inf.size() + m_buf.size()) < DEPTH);
        exp_valid = (m_buf.size() > 0);
        head_pc   = exp_valid ? m_buf[0] : 32'h0;
        if (m_known) begin
            check_eq("mem_read_en", {31'h0, mem_read_en}, {31'h0, exp_issue});
            check_eq("mem_addr", mem_addr, exp_issue ? m_pc : 32'h0);
            check_eq("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
            check_eq("inst_pc", inst_pc, head_pc);
            check_eq("inst", inst, exp_valid ? mem_word(head_pc) : 32'h0);
`ifdef FETCH_PERF_EN
            check_eq("perf_issue", perf_issue_cnt, m_issue_cnt);
            check_eq("perf_drop", perf_drop_cnt, m_drop_cnt);
            check_eq("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif
        end
        if (!rn) begin
            m_known = 1'b1;
            m_pc    = RESET_PC;
            m_inf.delete();
            m_buf.delete();
            m_issue_cnt = 32'h0;
            m_drop_cnt  = 32'h0;
            m_stall_cnt = 32'h0;
        end else begin
            m_issue_cnt += {31'h0, exp_issue};
            m_stall_cnt += {31'h0, exp_valid && !rdy};
            if (rv) begin
                m_drop_cnt += 32'(m_inf.size());
                m_inf.delete();
                m_buf.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (exp_valid && rdy) void'(m_buf.pop_front());
                if (m_inf.size() > 0 && m_inf[0].due == cyc) m_buf.push_back(m_inf.pop_front().pc);
                if (exp_issue) begin
                    m_inf.push_back('{pc: m_pc, due: cyc + 2});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        // Reset, then streaming with decode always ready
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Backpressure, then release
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Redirect with requests in flight and entries buffered
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Misaligned redirect with a pending pop
        step(1'b1, 1'b1, 32'h47, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Back-to-back redirects
        step(1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'hC0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // fetch_en gap
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // PC wrap, then a redirect while two requests are in flight
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Reset mid-operation
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 $urandom,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
